plic_src_filter: RTL and testbench



---
 rtl/plic_src_filter.sv | 116 +++++++++++
 tb/tb_plic_src_filter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_src_filter.sv
// plic_src_filter: per-source input conditioner in front of the PLIC gateways.
// Each source is synchronised into clk, polarity-corrected, and then passed
// through a pulse-width qualifier. src only changes after flt_len+1
// consecutive disagreeing samples. chg and glitch report accepted changes and
// aborted qualifications as one-cycle registered pulses.
module plic_src_filter #(
    parameter int SOURCES     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_BITS = 4
) (
    input  logic                   rst_n,
    input  logic                   clk,
    input  logic [SOURCES-1:0]     src_async,
    input  logic [SOURCES-1:0]     inv,
    input  logic [FILTER_BITS-1:0] flt_len [SOURCES],
    output logic [SOURCES-1:0]     src,
    output logic [SOURCES-1:0]     chg,
    output logic [SOURCES-1:0]     glitch
);

    // Filter states. The counter is zero whenever the state is STABLE.
    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_QUAL   = 1'b1;

    localparam logic [FILTER_BITS-1:0] CNT_ONE  = {{(FILTER_BITS-1){1'b0}}, 1'b1};
    localparam logic [FILTER_BITS-1:0] CNT_ZERO = {FILTER_BITS{1'b0}};

    for (genvar s = 0; s < SOURCES; s++) begin : g_src
        logic [SYNC_STAGES-1:0] r_sync;
        logic [0:0]             r_state;
        logic [FILTER_BITS-1:0] r_cnt;
        logic                   r_src;
        logic                   r_chg;
        logic                   r_glitch;

        logic                   w_p;
        logic [0:0]             w_state_nxt;
        logic [FILTER_BITS-1:0] w_cnt_nxt;
        logic                   w_src_nxt;
        logic                   w_chg_nxt;
        logic                   w_glitch_nxt;

        // Synchroniser chain. Polarity is applied before the first flop. A
        // freshly reset chain therefore reads as "inactive" for either
        // polarity, and a request present at reset release sees the full
        // synchroniser latency.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], src_async[s] ^ inv[s]};
            end
        end

        assign w_p = r_sync[SYNC_STAGES-1];

        // Qualification decision on the current polarised sample.
        always_comb begin
            w_state_nxt  = r_state;
            w_cnt_nxt    = r_cnt;
            w_src_nxt    = r_src;
            w_chg_nxt    = 1'b0;
            w_glitch_nxt = 1'b0;
            if (w_p != r_src) begin
                // The >= compare lets a lowered flt_len take effect at once.
                if (r_cnt >= flt_len[s]) begin
                    w_src_nxt   = w_p;
                    w_cnt_nxt   = CNT_ZERO;
                    w_chg_nxt   = 1'b1;
                    w_state_nxt = ST_STABLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                    w_state_nxt = ST_QUAL;
                end
            end else begin
                case (r_state)
                    ST_QUAL: begin
                        w_cnt_nxt    = CNT_ZERO;
                        w_glitch_nxt = 1'b1;
                        w_state_nxt  = ST_STABLE;
                    end
                    ST_STABLE: begin
                        w_cnt_nxt   = r_cnt;
                        w_state_nxt = ST_STABLE;
                    end
                    default: begin
                        w_cnt_nxt   = CNT_ZERO;
                        w_state_nxt = ST_STABLE;
                    end
                endcase
            end
        end

        // Filter state, counter and registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state  <= ST_STABLE;
                r_cnt    <= CNT_ZERO;
                r_src    <= 1'b0;
                r_chg    <= 1'b0;
                r_glitch <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_cnt    <= w_cnt_nxt;
                r_src    <= w_src_nxt;
                r_chg    <= w_chg_nxt;
                r_glitch <= w_glitch_nxt;
            end
        end

        assign src[s]    = r_src;
        assign chg[s]    = r_chg;
        assign glitch[s] = r_glitch;
    end

endmodule

// File: tb/tb_plic_src_filter.sv
// Bench for plic_src_filter: directed scenarios with literal expectations plus
// a history-based reference model that is compared against the DUT each cycle.
module tb_plic_src_filter;
    localparam int SRC  = 8;
    localparam int SYNC = 2;

    logic            clk;
    logic            rst_n;
    logic [SRC-1:0]  src_async;
    logic [SRC-1:0]  inv;
    logic [3:0]      flt_len [SRC];
    logic [SRC-1:0]  src;
    logic [SRC-1:0]  chg;
    logic [SRC-1:0]  glitch;

    int n_checks = 0;
    int n_fail   = 0;

    plic_src_filter #(.SOURCES(SRC), .SYNC_STAGES(SYNC), .FILTER_BITS(4)) dut (
        .rst_n(rst_n), .clk(clk), .src_async(src_async), .inv(inv),
        .flt_len(flt_len), .src(src), .chg(chg), .glitch(glitch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model.
    // The model keeps the history of polarised samples p.
    // src flips when the last flt_len+1 samples all disagree with it.
    // glitch fires when p agrees again right after a disagreeing sample
    // that did not cause a flip.
    logic [SRC-1:0] pq[$];
    logic [SRC-1:0] ph[$];
    logic [SRC-1:0] e_src = '0;
    logic [SRC-1:0] e_chg = '0;
    logic [SRC-1:0] e_glitch = '0;

    initial forever begin
        logic [SRC-1:0] p;
        logic [SRC-1:0] ns;
        logic           all_mis;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            pq.delete();
            ph.delete();
            e_src = '0;
            e_chg = '0;
            e_glitch = '0;
        end else begin
            p = (pq.size() >= SYNC) ? pq[pq.size() - SYNC] : '0;
            pq.push_back(src_async ^ inv);
            if (pq.size() > 8) void'(pq.pop_front());
            ph.push_back(p);
            if (ph.size() > 20) void'(ph.pop_front());
            ns = e_src;
            e_chg = '0;
            e_glitch = '0;
            for (int s = 0; s < SRC; s++) begin
                if (p[s] != e_src[s]) begin
                    all_mis = 1'b1;
                    for (int k = 0; k <= int'(flt_len[s]); k++) begin
                        if (k >= ph.size()) all_mis = 1'b0;
                        else if (ph[ph.size() - 1 - k][s] == e_src[s]) all_mis = 1'b0;
                    end
                    if (all_mis) begin
                        ns[s] = p[s];
                        e_chg[s] = 1'b1;
                    end
                end else if (ph.size() >= 2 && ph[ph.size() - 2][s] != e_src[s]) begin
                    e_glitch[s] = 1'b1;
                end
            end
            e_src = ns;
        end
    end

    // Compare process: DUT against the model, every cycle.
    initial forever begin
        @(posedge clk);
        #1;
        chk("model_src", 32'(src), 32'(e_src));
        chk("model_chg", 32'(chg), 32'(e_chg));
        chk("model_glitch", 32'(glitch), 32'(e_glitch));
    end

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gcnt;
        int gedge;
        logic seen_hi;

        rst_n = 1'b0;
        src_async = '0;
        inv = '0;
        for (int i = 0; i < SRC; i++) flt_len[i] = 4'd0;
        flt_len[2] = 4'd5;
        flt_len[3] = 4'd15;
        flt_len[4] = 4'd5;

        // 1. Reset values.
        repeat (3) edge_();
        chk("rst_src", 32'(src), 32'd0);
        chk("rst_pulses", 32'({chg, glitch}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            edge_();
            chk("idle_outs", 32'({src, chg, glitch}), 32'd0);
        end

        // 2. Minimum latency on source 0.
        @(negedge clk);
        src_async[0] = 1'b1;
        edge_(); chk("lat_e1", 32'(src[0]), 32'd0);
        edge_(); chk("lat_e2", 32'(src[0]), 32'd0);
        edge_(); chk("lat_e3_src", 32'(src[0]), 32'd1);
        chk("lat_e3_chg", 32'(chg[0]), 32'd1);
        edge_(); chk("lat_e4_chg", 32'(chg[0]), 32'd0);
        @(negedge clk);
        src_async[0] = 1'b0;
        edge_(); edge_(); chk("fall_e2", 32'(src[0]), 32'd1);
        edge_(); chk("fall_e3", 32'(src[0]), 32'd0);
        chk("fall_e3_chg", 32'(chg[0]), 32'd1);

        // 3a. 5-cycle pulse on source 2 (flt_len 5) is rejected.
        gcnt = 0; gedge = 0; seen_hi = 1'b0;
        @(negedge clk);
        src_async[2] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            if (e == 6) begin
                @(negedge clk);
                src_async[2] = 1'b0;
            end
            edge_();
            if (glitch[2]) begin gcnt++; gedge = e; end
            if (src[2]) seen_hi = 1'b1;
        end
        chk("p5_glitch_cnt", 32'(gcnt), 32'd1);
        chk("p5_glitch_edge", 32'(gedge), 32'd8);
        chk("p5_src_never", 32'(seen_hi), 32'd0);

        // 3b. 6-cycle pulse on source 2 propagates at edge 8, clears at edge 14.
        gcnt = 0;
        @(negedge clk);
        src_async[2] = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            if (e == 7) begin
                @(negedge clk);
                src_async[2] = 1'b0;
            end
            edge_();
            if (glitch[2]) gcnt++;
            if (e == 7)  chk("p6_e7", 32'(src[2]), 32'd0);
            if (e == 8)  chk("p6_e8", 32'({src[2], chg[2]}), 32'd3);
            if (e == 13) chk("p6_e13", 32'(src[2]), 32'd1);
            if (e == 14) chk("p6_e14", 32'(src[2]), 32'd0);
        end
        chk("p6_no_glitch", 32'(gcnt), 32'd0);

        // 4. Active-low source 1, pin low through reset release.
        @(negedge clk);
        rst_n = 1'b0;
        inv[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        edge_(); chk("inv_e1", 32'(src[1]), 32'd0);
        edge_(); chk("inv_e2", 32'(src[1]), 32'd0);
        edge_(); chk("inv_e3", 32'(src[1]), 32'd1);
        @(negedge clk);
        src_async[1] = 1'b1;
        edge_(); edge_(); chk("inv_off_e2", 32'(src[1]), 32'd1);
        edge_(); chk("inv_off_e3", 32'(src[1]), 32'd0);

        // 5. flt_len lowered from 15 to 4 after 8 counted mismatches.
        gcnt = 0;
        @(negedge clk);
        src_async[3] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            edge_();
            if (glitch[3]) gcnt++;
        end
        chk("low_e10", 32'(src[3]), 32'd0);
        @(negedge clk);
        flt_len[3] = 4'd4;
        edge_();
        chk("low_e11", 32'({src[3], chg[3], glitch[3]}), 32'b110);
        chk("low_no_glitch", 32'(gcnt), 32'd0);

        // 6. Reset mid-qualification on source 4, source 5 toggled alongside.
        @(negedge clk);
        src_async[4] = 1'b1;
        src_async[5] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            edge_();
            if (e == 3) chk("ind_src5", 32'(src[5]), 32'd1);
        end
        chk("mid_src4", 32'(src[4]), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'({src, chg, glitch}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            edge_();
            if (e == 3) chk("rel_src5", 32'(src[5]), 32'd1);
            if (e == 7) chk("rel_src4_e7", 32'(src[4]), 32'd0);
            if (e == 8) chk("rel_src4_e8", 32'(src[4]), 32'd1);
        end
        chk("rel_src1_quiet", 32'(src[1]), 32'd0);

        // Mixed traffic against the model: sparse pin toggles, short lengths.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < SRC; i++) begin
                if ($urandom_range(0, 3) == 0) src_async[i] = ~src_async[i];
            end
            if ($urandom_range(0, 15) == 0) begin
                flt_len[$urandom_range(0, SRC - 1)] = 4'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 63) == 0) inv[$urandom_range(0, SRC - 1)] ^= 1'b1;
        end
        repeat (20) edge_();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
